// File: rtl/maxpool2x2_if.sv
// Pixel stream into the 2x2 max-pool stage and pooled pixel stream out of it.
interface maxpool2x2_if #(
  parameter int N       = 16,
  parameter int CHANNEL = 32
);
  logic                   input_vld;
  logic [CHANNEL*N-1:0]   input_din;
  logic [CHANNEL*N-1:0]   pool_dout;
  logic                   pool_dout_vld;
  logic                   pool_dout_end;

  modport master (
    output input_vld,
    output input_din,
    input  pool_dout,
    input  pool_dout_vld,
    input  pool_dout_end
  );

  modport slave (
    input  input_vld,
    input  input_din,
    output pool_dout,
    output pool_dout_vld,
    output pool_dout_end
  );
endinterface

// File: rtl/maxpool2x2.sv
// Streaming 2x2 stride-2 max pooling over raster-ordered multi-channel pixels,
// using a half-row line buffer of horizontal pair maxima.
module maxpool2x2 #(
  parameter int N          = 16,
  parameter int CHANNEL    = 32,
  parameter int INPUT_SIZE = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  maxpool2x2_if.slave  bus
);
  localparam int W    = CHANNEL * N;
  localparam int HALF = INPUT_SIZE / 2;
  localparam int CW   = (INPUT_SIZE > 2) ? $clog2(INPUT_SIZE) : 1;
  localparam int LW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(INPUT_SIZE - 1);

  logic [CW-1:0] col_q, col_d, row_q, row_d;
  logic [W-1:0]  pair_q, pair_d, dout_q, dout_d;
  logic          vld_q, vld_d, end_q, end_d, final_q, final_d;
  logic [W-1:0]  lbuf_q [HALF];
  logic [LW-1:0] lbuf_idx;
  logic [W-1:0]  lbuf_rd, hmax;
  logic          lbuf_we, clear;

  function automatic logic [W-1:0] chan_max(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < CHANNEL; k++) begin
      r[k*N +: N] = ($signed(a[k*N +: N]) > $signed(b[k*N +: N])) ? a[k*N +: N] : b[k*N +: N];
    end
    return r;
  endfunction

  assign clear    = !rst_n || !ce;
  assign lbuf_idx = LW'(col_q >> 1);
  assign lbuf_rd  = lbuf_q[lbuf_idx];
  assign hmax     = chan_max(pair_q, bus.input_din);

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    pair_d  = pair_q;
    dout_d  = dout_q;
    vld_d   = 1'b0;
    final_d = 1'b0;
    end_d   = end_q;
    lbuf_we = 1'b0;
    // The frame is complete on the edge after its last pulse is shown.
    if (final_q) end_d = 1'b1;
    if (bus.input_vld) begin
      if (col_q == '0 && row_q == '0) end_d = 1'b0;
      if (col_q == LAST) begin
        col_d = '0;
        row_d = (row_q == LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (!col_q[0]) begin
        pair_d = bus.input_din;
      end else if (!row_q[0]) begin
        lbuf_we = 1'b1;
      end else begin
        dout_d  = chan_max(lbuf_rd, hmax);
        vld_d   = 1'b1;
        final_d = (row_q == LAST) && (col_q == LAST);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      col_q   <= '0;
      row_q   <= '0;
      pair_q  <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      final_q <= 1'b0;
      end_q   <= 1'b1;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      pair_q  <= pair_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      final_q <= final_d;
      end_q   <= end_d;
    end
  end

  // Every entry is written on an even row before the odd row reads it, so no clear is needed.
  always_ff @(posedge clk) begin
    if (lbuf_we && !clear) lbuf_q[lbuf_idx] <= hmax;
  end

  assign bus.pool_dout     = dout_q;
  assign bus.pool_dout_vld = vld_q;
  assign bus.pool_dout_end = end_q;
endmodule
